reg_bus_arbiter: RTL and testbench
==================================

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 4: read-wait cycles without dout_vld before error completion; legal range 1..15.
REQ-002 Parameter DATA_W, default 32: data width; ADDR_W, default 3: address width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 m0_req, m1_req  input  1 each  requester transaction request; held high until that requester's ack.
REQ-006 m0_wr, m1_wr  input  1 each  1=write, 0=read; stable while req high.
REQ-007 m0_addr, m1_addr  input  3 each  register address; stable while req high.
REQ-008 m0_wdata, m1_wdata  input  32 each  write data; stable while req high.
REQ-009 m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
REQ-010 m0_err, m1_err  output  1 each  error flag, valid only with ack.
REQ-011 m0_rdata, m1_rdata  output  32 each  read data, valid only with ack of a successful read.
REQ-012 wr_en, addr_vld  output  1 each  register-file command strobes.
REQ-013 addr  output  3  register-file address.
REQ-014 din  output  32  register-file write data.
REQ-015 dout  input  32  register-file read data; dout_vld  input  1  read-data valid.

Function
REQ-016 FSM states IDLE, WR, RD, WAIT, DONE; all outputs registered.
REQ-017 IDLE: no req -> stay; any req -> grant per round-robin, latch master id, wr, addr, wdata.
REQ-018 Round-robin: both req in IDLE -> grant the master not granted last; after reset m0 wins first tie.
REQ-019 Granted addr[2]=1 (addresses 4..7) -> DONE directly, err=1, rdata=0, no bus strobe issued.
REQ-020 Write grant -> WR: exactly one cycle wr_en=1, addr_vld=1, addr, din driven; next state DONE.
REQ-021 Read grant -> RD: exactly one cycle wr_en=0, addr_vld=1, addr driven; next state WAIT.
REQ-022 Outside WR/RD, addr_vld=0 and wr_en=0; addr and din hold last value.
REQ-023 WAIT: dout_vld=1 -> capture dout into granted rdata, err=0, go DONE.
REQ-024 WAIT: TIMEOUT consecutive cycles with dout_vld=0 -> err=1, rdata=0, go DONE; counter cleared on entry.
REQ-025 dout_vld outside WAIT is ignored.
REQ-026 DONE: granted ack=1 for exactly this cycle, other ack=0; next state IDLE unconditionally; req ignored in DONE.
REQ-027 Latency, req seen in IDLE at cycle 0: write strobe cycle 1, ack cycle 2; read strobe cycle 1, dout_vld cycle 2, ack cycle 3; bad address ack cycle 1.
REQ-028 Non-granted requester waits with req high; no request is dropped or reordered.
REQ-029 rdata of each master holds its last captured value between acks.

Reset
REQ-030 rst high -> immediately: state IDLE, all acks/errs 0, rdata 0, wr_en 0, addr_vld 0, addr 0, din 0, timeout counter 0, round-robin pointer to m0.
REQ-031 Reset mid-transaction abandons it without ack; requester reissues after reset.

Structure
REQ-032 Package reg_arb_pkg holds the state enum, DATA_W/ADDR_W defaults, and REG_COUNT=4.
REQ-033 Sub-module reg_arb_rr2 (two-way round-robin grant plus last-grant pointer) is the single permitted sub-module.

Verification
REQ-034 m0 write addr 2 data 0xDEADBEEF -> cycle 1 wr_en=1, addr_vld=1, addr=2, din=0xDEADBEEF; m0_ack, m0_err=0 at cycle 2.
REQ-035 m1 read addr 2 after REQ-034, bench model returns dout_vld cycle 2 -> m1_ack cycle 3, m1_rdata=0xDEADBEEF, m1_err=0.
REQ-036 m0 and m1 request simultaneously, three rounds each -> grant order m0,m1,m0,m1,m0,m1; no missing acks.
REQ-037 m0 read addr 1, dout_vld held 0 -> m0_ack with m0_err=1, rdata=0, at cycle 2+TIMEOUT (cycle 6 default).
REQ-038 m1 write addr 5 -> no addr_vld pulse; m1_ack, m1_err=1 at cycle 1.
REQ-039 rst asserted in WAIT -> all outputs 0 asynchronously; after release m1/m0 tie grants m0.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the two-master register-bus arbiter.
package reg_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;
  // Addresses at or above REG_COUNT complete with an error and never reach the bus
  localparam int REG_COUNT  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Requester handshakes and register-file command/response signals of the arbiter.
interface reg_bus_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              m0_req, m1_req;
  logic              m0_wr, m1_wr;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_ack, m1_ack;
  logic              m0_err, m1_err;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              wr_en, addr_vld;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;

  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  dout, dout_vld,
    output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
    output wr_en, addr_vld, addr, din
  );

  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output dout, dout_vld,
    input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
    input  wr_en, addr_vld, addr, din
  );

endinterface

// File: rtl/reg_arb_rr2.sv
// Two-way round-robin grant: combinational one-hot grant plus a registered
// priority pointer that flips to the other master whenever a grant is taken.
module reg_arb_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic prio_m1;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio_m1 ? 2'b10 : 2'b01;
  end

  // Pointer starts on m0 so the first tie after reset goes to m0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       prio_m1 <= 1'b0;
    else if (take) prio_m1 <= gnt[0];
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Arbitrates two requesters onto a single register-file port with one
// transaction in flight, read timeout, and out-of-range address rejection.
module reg_bus_arbiter
  import reg_arb_pkg::*;
#(
  parameter int TIMEOUT = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input logic              clk,
  input logic              rst,
  reg_bus_arbiter_if.slave bus
);

  state_t            state, state_nxt;
  logic              gnt_m1, gnt_m1_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [1:0]        gnt;
  logic              take;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              fin, fin_err, fin_rd, fin_m1;
  logic              m0_ack_nxt, m1_ack_nxt, m0_err_nxt, m1_err_nxt;
  logic              wr_en_nxt, addr_vld_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] din_nxt, m0_rdata_nxt, m1_rdata_nxt;

  assign take = (state == ST_IDLE) && (|gnt);

  reg_arb_rr2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .req  ({bus.m1_req, bus.m0_req}),
    .take (take),
    .gnt  (gnt)
  );

  always_comb begin
    sel_wr    = gnt[1] ? bus.m1_wr    : bus.m0_wr;
    sel_addr  = gnt[1] ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = gnt[1] ? bus.m1_wdata : bus.m0_wdata;
  end

  // Outputs are computed for the state being entered, then registered with it
  always_comb begin
    state_nxt    = state;
    gnt_m1_nxt   = gnt_m1;
    cnt_nxt      = cnt;
    wr_en_nxt    = 1'b0;
    addr_vld_nxt = 1'b0;
    addr_nxt     = bus.addr;
    din_nxt      = bus.din;
    fin          = 1'b0;
    fin_err      = 1'b0;
    fin_rd       = 1'b0;
    fin_m1       = gnt_m1;
    case (state)
      ST_IDLE: begin
        if (take) begin
          gnt_m1_nxt = gnt[1];
          fin_m1     = gnt[1];
          if (sel_addr >= ADDR_W'(REG_COUNT)) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            addr_vld_nxt = 1'b1;
            addr_nxt     = sel_addr;
            if (sel_wr) begin
              wr_en_nxt = 1'b1;
              din_nxt   = sel_wdata;
              state_nxt = ST_WR;
            end else begin
              state_nxt = ST_RD;
            end
          end
        end
      end
      ST_WR: fin = 1'b1;
      ST_RD: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = '0;
      end
      ST_WAIT: begin
        if (bus.dout_vld) begin
          fin    = 1'b1;
          fin_rd = 1'b1;
        end else if (cnt == 4'(TIMEOUT - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (fin) state_nxt = ST_DONE;

    m0_ack_nxt   = fin && !fin_m1;
    m1_ack_nxt   = fin && fin_m1;
    m0_err_nxt   = m0_ack_nxt && fin_err;
    m1_err_nxt   = m1_ack_nxt && fin_err;
    m0_rdata_nxt = bus.m0_rdata;
    m1_rdata_nxt = bus.m1_rdata;
    // Write completions leave rdata untouched; errors clear it
    if (fin && (fin_err || fin_rd)) begin
      if (fin_m1) m1_rdata_nxt = fin_err ? '0 : bus.dout;
      else        m0_rdata_nxt = fin_err ? '0 : bus.dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      gnt_m1       <= 1'b0;
      cnt          <= '0;
      bus.m0_ack   <= 1'b0;
      bus.m1_ack   <= 1'b0;
      bus.m0_err   <= 1'b0;
      bus.m1_err   <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m1_rdata <= '0;
      bus.wr_en    <= 1'b0;
      bus.addr_vld <= 1'b0;
      bus.addr     <= '0;
      bus.din      <= '0;
    end else begin
      state        <= state_nxt;
      gnt_m1       <= gnt_m1_nxt;
      cnt          <= cnt_nxt;
      bus.m0_ack   <= m0_ack_nxt;
      bus.m1_ack   <= m1_ack_nxt;
      bus.m0_err   <= m0_err_nxt;
      bus.m1_err   <= m1_err_nxt;
      bus.m0_rdata <= m0_rdata_nxt;
      bus.m1_rdata <= m1_rdata_nxt;
      bus.wr_en    <= wr_en_nxt;
      bus.addr_vld <= addr_vld_nxt;
      bus.addr     <= addr_nxt;
      bus.din      <= din_nxt;
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: a register-file model answers reads,
// and a scoreboard of expected completions is checked on every ack.
module tb_reg_bus_arbiter;

  localparam int TMO = 4;

  typedef struct {
    bit          m1;
    bit          err;
    bit          chk_rd;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] mem [0:7];
  logic        respond;
  logic        pending;
  logic [2:0]  raddr;

  reg_bus_arbiter_if bus ();

  reg_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register-file model: read data returned the cycle after the read strobe
  always @(negedge clk) begin
    if (rst) begin
      pending      <= 1'b0;
      bus.dout_vld <= 1'b0;
    end else begin
      bus.dout_vld <= 1'b0;
      pending      <= 1'b0;
      if (pending && respond) begin
        bus.dout_vld <= 1'b1;
        bus.dout     <= mem[raddr];
      end
      if (bus.addr_vld && !bus.wr_en) begin
        pending <= 1'b1;
        raddr   <= bus.addr;
      end
      if (bus.addr_vld && bus.wr_en) mem[bus.addr] <= bus.din;
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    if (!rst && (bus.m0_ack || bus.m1_ack)) begin
      check("sb_has_entry_at_ack", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("ack_onehot", {62'd0, bus.m1_ack, bus.m0_ack}, e.m1 ? 64'd2 : 64'd1);
        check("ack_cycle", 64'(cyc), 64'(e.cyc));
        check("ack_err", e.m1 ? bus.m1_err : bus.m0_err, 64'(e.err));
        if (e.chk_rd) check("ack_rdata", e.m1 ? bus.m1_rdata : bus.m0_rdata, e.rdata);
      end
    end
  end

  task automatic issue(input bit m1, input bit wr, input logic [2:0] a, input logic [31:0] wd,
                       input bit push, input bit err, input bit chk_rd, input logic [31:0] rd,
                       input int lat);
    @(negedge clk);
    if (m1) begin
      bus.m1_wr = wr; bus.m1_addr = a; bus.m1_wdata = wd; bus.m1_req = 1'b1;
    end else begin
      bus.m0_wr = wr; bus.m0_addr = a; bus.m0_wdata = wd; bus.m0_req = 1'b1;
    end
    if (push) sb.push_back('{m1, err, chk_rd, rd, cyc + lat});
  endtask

  task automatic wait_ack(input bit m1);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m1 ? bus.m1_ack : bus.m0_ack) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (m1) bus.m1_req = 1'b0;
    else    bus.m0_req = 1'b0;
    check("ack_within_budget", 64'(seen), 64'd1);
  endtask

  // Both masters request together and re-request right after each ack
  task automatic run_tie(input int rounds);
    int c, n0, n1;
    @(negedge clk);
    bus.m0_wr = 1'b1; bus.m0_addr = 3'd0; bus.m0_wdata = 32'h1111_0000;
    bus.m1_wr = 1'b1; bus.m1_addr = 3'd1; bus.m1_wdata = 32'h2222_0000;
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    c = cyc;
    for (int k = 0; k < 2 * rounds; k++) sb.push_back('{(k % 2) == 1, 1'b0, 1'b0, 32'd0, c + 2 + 3 * k});
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 6 * rounds + 20; i++) begin
      @(negedge clk);
      if (bus.m0_ack) begin
        n0++;
        bus.m0_wdata = bus.m0_wdata + 32'd1;
        if (n0 == rounds) bus.m0_req = 1'b0;
      end
      if (bus.m1_ack) begin
        n1++;
        bus.m1_wdata = bus.m1_wdata + 32'd1;
        if (n1 == rounds) bus.m1_req = 1'b0;
      end
      if (n0 == rounds && n1 == rounds) break;
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    check("tie_m0_acks", 64'(n0), 64'(rounds));
    check("tie_m1_acks", 64'(n1), 64'(rounds));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    rst = 1'b1;
    respond = 1'b1;
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.m0_wr = 1'b0; bus.m1_wr = 1'b0;
    bus.m0_addr = '0; bus.m1_addr = '0; bus.m0_wdata = '0; bus.m1_wdata = '0;
    bus.dout = '0; bus.dout_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m0_ack", bus.m0_ack, 0);
    check("rst_m1_ack", bus.m1_ack, 0);
    check("rst_m0_err", bus.m0_err, 0);
    check("rst_m1_err", bus.m1_err, 0);
    check("rst_m0_rdata", bus.m0_rdata, 0);
    check("rst_m1_rdata", bus.m1_rdata, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_addr_vld", bus.addr_vld, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_din", bus.din, 0);
    rst = 1'b0;
    @(negedge clk);

    // m0 write addr 2
    issue(1'b0, 1'b1, 3'd2, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'd0, 2);
    @(negedge clk);
    check("wr_strobe_wr_en", bus.wr_en, 1);
    check("wr_strobe_addr_vld", bus.addr_vld, 1);
    check("wr_strobe_addr", bus.addr, 2);
    check("wr_strobe_din", bus.din, 32'hDEAD_BEEF);
    wait_ack(1'b0);
    @(negedge clk);
    check("wr_strobe_single", bus.addr_vld, 0);

    // m1 read addr 2
    issue(1'b1, 1'b0, 3'd2, 32'd0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 3);
    @(negedge clk);
    check("rd_strobe_addr_vld", bus.addr_vld, 1);
    check("rd_strobe_wr_en", bus.wr_en, 0);
    check("rd_strobe_addr", bus.addr, 2);
    wait_ack(1'b1);

    // Three contended rounds
    run_tie(3);
    check("m1_rdata_held", bus.m1_rdata, 32'hDEAD_BEEF);

    // m0 read of last value written by m0, then a timed-out read
    issue(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'h1111_0002, 3);
    wait_ack(1'b0);
    respond = 1'b0;
    issue(1'b0, 1'b0, 3'd1, 32'd0, 1'b1, 1'b1, 1'b1, 32'd0, 2 + TMO);
    wait_ack(1'b0);
    respond = 1'b1;

    // m1 write to out-of-range address
    issue(1'b1, 1'b1, 3'd5, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b1, 32'd0, 1);
    @(negedge clk);
    check("bad_addr_no_strobe", bus.addr_vld, 0);
    wait_ack(1'b1);

    // Reset while waiting for read data
    respond = 1'b0;
    issue(1'b0, 1'b0, 3'd3, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
    @(negedge clk);
    check("pre_rst_addr", bus.addr, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_addr", bus.addr, 0);
    check("async_rst_din", bus.din, 0);
    check("async_rst_addr_vld", bus.addr_vld, 0);
    check("async_rst_m0_ack", bus.m0_ack, 0);
    bus.m0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    respond = 1'b1;
    run_tie(1);

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
